// File: rtl/lcd_pattern_gen.sv
// ---------------------------------------------------------------------------
// lcd_pattern_gen
//   RGB565 test-pattern generator for the LCD display path. Takes pixel
//   coordinates and a data request from the LCD timing driver. One cycle
//   later it returns a registered pixel from one of six patterns:
//     0 colour bars, 1 checkerboard, 2 horizontal ramp, 3 vertical ramp,
//     4 grid, 5 bouncing box (6/7 reserved, black).
//   The pattern select is latched only at frame start, so a frame never tears.
//
// Ports
//   lcd_pclk     in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   data_req     in   pixel request for (pixel_xpos, pixel_ypos) this cycle
//   pixel_xpos   in   [10:0] active-area column
//   pixel_ypos   in   [10:0] active-area row
//   mode         in   [2:0] requested pattern, sampled at frame start
//   pixel_data   out  [15:0] RGB565 pixel, one cycle after the request
//   pixel_valid  out  registered copy of data_req
// ---------------------------------------------------------------------------
module lcd_pattern_gen #(
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 480,
  parameter int BAR_NUM    = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [2:0]  mode,
  output logic [15:0] pixel_data,
  output logic        pixel_valid
);

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_CHECK = 3'd1,
    PAT_HRAMP = 3'd2,
    PAT_VRAMP = 3'd3,
    PAT_GRID  = 3'd4,
    PAT_BOX   = 3'd5,
    PAT_RSV6  = 3'd6,
    PAT_RSV7  = 3'd7
  } pat_e;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  localparam logic [10:0] BAR_W_M1 = 11'((H_DISP / BAR_NUM) - 1);
  localparam logic [2:0]  BAR_LAST = 3'(BAR_NUM - 1);
  localparam logic [10:0] H_LAST   = 11'(H_DISP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_DISP - 1);
  localparam logic [10:0] BOX_XLIM = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] BOX_YLIM = 11'(V_DISP - BOX_SIZE);
  localparam logic [11:0] BOX_SZ12 = 12'(BOX_SIZE);

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

  // Takes coordinate bits [7:2]; the 5-bit fields reuse the top five of them.
  function automatic logic [15:0] ramp565(input logic [5:0] v);
    return {v[5:1], v, v[5:1]};
  endfunction

  // One bounce step along an axis: returns {dir_next, pos_next}.
  function automatic logic [11:0] axis_step(input logic [10:0] pos,
                                            input logic        dir,
                                            input logic [10:0] lim);
    if (!dir) begin
      if (pos == lim) return {1'b1, pos - 11'd1};
      else            return {1'b0, pos + 11'd1};
    end else begin
      if (pos == 11'd0) return {1'b0, pos + 11'd1};
      else              return {1'b1, pos - 11'd1};
    end
  endfunction

  pat_e        mode_q;
  logic [2:0]  bar_idx_q;
  logic [10:0] bar_cnt_q;
  logic [10:0] box_x_q, box_y_q;
  logic        dir_x_q, dir_y_q;
  logic [15:0] pix_p1;
  logic        vld_p1;

  logic        frame_start, line_start, box_hit;
  pat_e        mode_cur;
  logic [2:0]  bar_idx_cur;
  logic [10:0] bar_cnt_cur;
  logic [11:0] step_x, step_y;
  logic [15:0] pix_p0;

  // Stage p0: decode request, advance bar counters, evaluate the pattern
  always_comb begin
    frame_start = data_req && (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    line_start  = data_req && (pixel_xpos == 11'd0);
    mode_cur    = frame_start ? pat_e'(mode) : mode_q;

    // Counters describe the current pixel, so the first pixel of bar k
    // lands exactly on x = k*W.
    bar_idx_cur = bar_idx_q;
    bar_cnt_cur = bar_cnt_q;
    if (line_start) begin
      bar_idx_cur = 3'd0;
      bar_cnt_cur = 11'd0;
    end else if (data_req) begin
      if ((bar_cnt_q == BAR_W_M1) && (bar_idx_q < BAR_LAST)) begin
        bar_idx_cur = bar_idx_q + 3'd1;
        bar_cnt_cur = 11'd0;
      end else begin
        bar_cnt_cur = bar_cnt_q + 11'd1;
      end
    end

    box_hit = ({1'b0, pixel_xpos} >= {1'b0, box_x_q}) &&
              ({1'b0, pixel_xpos} <  ({1'b0, box_x_q} + BOX_SZ12)) &&
              ({1'b0, pixel_ypos} >= {1'b0, box_y_q}) &&
              ({1'b0, pixel_ypos} <  ({1'b0, box_y_q} + BOX_SZ12));

    step_x = axis_step(box_x_q, dir_x_q, BOX_XLIM);
    step_y = axis_step(box_y_q, dir_y_q, BOX_YLIM);

    pix_p0 = BLACK;
    if (data_req) begin
      case (mode_cur)
        PAT_BARS:  pix_p0 = bar_color(bar_idx_cur);
        PAT_CHECK: pix_p0 = (pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2]) ? WHITE : BLACK;
        PAT_HRAMP: pix_p0 = ramp565(pixel_xpos[7:2]);
        PAT_VRAMP: pix_p0 = ramp565(pixel_ypos[7:2]);
        PAT_GRID:  pix_p0 = ((pixel_xpos[3:0] == 4'd0) || (pixel_ypos[3:0] == 4'd0) ||
                             (pixel_xpos == H_LAST) || (pixel_ypos == V_LAST)) ? WHITE : BLACK;
        PAT_BOX:   pix_p0 = box_hit ? RED : BLUE;
        default:   pix_p0 = BLACK;
      endcase
    end
  end

  // Stage p1: registered pixel output and per-frame state
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= PAT_BARS;
      bar_idx_q <= 3'd0;
      bar_cnt_q <= 11'd0;
      box_x_q   <= 11'd0;
      box_y_q   <= 11'd0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      pix_p1    <= BLACK;
      vld_p1    <= 1'b0;
    end else begin
      pix_p1    <= pix_p0;
      vld_p1    <= data_req;
      bar_idx_q <= bar_idx_cur;
      bar_cnt_q <= bar_cnt_cur;
      // Box moves once per frame, after the frame-start pixel used the old position.
      if (frame_start) begin
        mode_q  <= mode_cur;
        dir_x_q <= step_x[11];
        box_x_q <= step_x[10:0];
        dir_y_q <= step_y[11];
        box_y_q <= step_y[10:0];
      end
    end
  end

  assign pixel_data  = pix_p1;
  assign pixel_valid = vld_p1;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
module tb_lcd_pattern_gen;

  logic        lcd_pclk = 1'b0;
  logic        rst_n;
  logic        data_req;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic [2:0]  mode;
  logic [15:0] pixel_data, pixel_data3;
  logic        pixel_valid, pixel_valid3;

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_pattern_gen dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .data_req(data_req),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .mode(mode),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid)
  );

  lcd_pattern_gen #(.BAR_NUM(3)) dut3 (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .data_req(data_req),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .mode(mode),
    .pixel_data(pixel_data3), .pixel_valid(pixel_valid3)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] data3;
    logic        valid;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_err    = 0;

  // Reference model state
  int m_mode = 0;
  int m_bx = 0, m_by = 0, m_dx = 0, m_dy = 0;

  logic [15:0] pal [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] model_pix(int md, int x, int y, int nbar);
    int idx;
    logic [10:0] v;
    case (md)
      0: begin
        idx = x / (800 / nbar);
        if (idx > nbar - 1) idx = nbar - 1;
        return pal[idx];
      end
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      2: begin v = 11'(x); return {v[7:3], v[7:2], v[7:3]}; end
      3: begin v = 11'(y); return {v[7:3], v[7:2], v[7:3]}; end
      4: return ((x % 16 == 0) || (y % 16 == 0) || (x == 799) || (y == 479)) ? 16'hFFFF : 16'h0000;
      5: return (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) ? 16'hF800 : 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic update_box();
    if (m_dx == 0) begin
      if (m_bx == 768) begin m_dx = 1; m_bx--; end else m_bx++;
    end else begin
      if (m_bx == 0) begin m_dx = 0; m_bx++; end else m_bx--;
    end
    if (m_dy == 0) begin
      if (m_by == 448) begin m_dy = 1; m_by--; end else m_by++;
    end else begin
      if (m_by == 0) begin m_dy = 0; m_by++; end else m_by--;
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request, push expectation, then compare the output it produced.
  task automatic step(input bit req, input int x, input int y);
    sb_t e;
    bit  fs;
    @(negedge lcd_pclk);
    data_req   = req;
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    fs = req && (x == 0) && (y == 0);
    if (fs) m_mode = int'(mode);
    e.valid = req;
    e.data  = req ? model_pix(m_mode, x, y, 8) : 16'h0000;
    e.data3 = req ? model_pix(m_mode, x, y, 3) : 16'h0000;
    sbq.push_back(e);
    if (fs) update_box();
    @(posedge lcd_pclk);
    #1;
    e = sbq.pop_front();
    chk16($sformatf("pix(%0d,%0d)", x, y), pixel_data, e.data);
    chk16($sformatf("pix3(%0d,%0d)", x, y), pixel_data3, e.data3);
    chk1($sformatf("valid(%0d,%0d)", x, y), pixel_valid, e.valid);
  endtask

  initial begin
    rst_n = 1'b0; data_req = 1'b0; pixel_xpos = '0; pixel_ypos = '0; mode = 3'd0;
    repeat (3) @(posedge lcd_pclk);
    #1;
    chk16("reset pixel_data", pixel_data, 16'h0000);
    chk1("reset pixel_valid", pixel_valid, 1'b0);
    @(negedge lcd_pclk) rst_n = 1'b1;

    // Colour bars, full line
    for (int x = 0; x < 800; x++) begin
      step(1, x, 0);
      if (x == 99)  chk16("bar8 x99",  pixel_data, 16'hFFFF);
      if (x == 100) chk16("bar8 x100", pixel_data, 16'hFFE0);
      if (x == 699) chk16("bar8 x699", pixel_data, 16'h001F);
      if (x == 700) chk16("bar8 x700", pixel_data, 16'h0000);
      if (x == 265) chk16("bar3 x265", pixel_data3, 16'hFFFF);
      if (x == 266) chk16("bar3 x266", pixel_data3, 16'hFFE0);
      if (x == 532) chk16("bar3 x532", pixel_data3, 16'h07FF);
      if (x == 799) chk16("bar3 x799", pixel_data3, 16'h07FF);
    end
    step(0, 0, 0);
    chk1("valid drops", pixel_valid, 1'b0);

    // Next line with 3-cycle request gaps across bar boundaries
    for (int x = 0; x < 800; x++) begin
      if (x == 100 || x == 300 || x == 532)
        for (int g = 0; g < 3; g++) step(0, x, 1);
      step(1, x, 1);
      if (x == 0)   chk16("bar3 new line x0", pixel_data3, 16'hFFFF);
      if (x == 100) chk16("gap bar8 x100", pixel_data, 16'hFFE0);
      if (x == 532) chk16("gap bar3 x532", pixel_data3, 16'h07FF);
    end

    // Checkerboard, then a mid-frame mode change that must wait for frame start
    mode = 3'd1;
    for (int x = 0; x <= 40; x++) begin
      step(1, x, 0);
      if (x == 31) chk16("checker (31,0)", pixel_data, 16'h0000);
      if (x == 32) chk16("checker (32,0)", pixel_data, 16'hFFFF);
    end
    for (int x = 0; x <= 40; x++) begin
      step(1, x, 32);
      if (x == 32) chk16("checker (32,32)", pixel_data, 16'h0000);
    end
    mode = 3'd2;
    for (int x = 0; x <= 40; x++) begin
      step(1, x, 33);
      if (x == 31) chk16("checker held (31,33)", pixel_data, 16'hFFFF);
    end
    for (int x = 0; x < 256; x++) begin
      step(1, x, 0);
      if (x == 0)   chk16("hramp (0,0)", pixel_data, 16'h0000);
      if (x == 255) chk16("hramp (255,0)", pixel_data, 16'hFFFF);
    end

    // Vertical ramp
    mode = 3'd3;
    step(1, 0, 0);
    for (int y = 1; y < 260; y += 37) step(1, 0, y);

    // Grid
    mode = 3'd4;
    step(1, 0, 0);
    for (int x = 0; x < 800; x++) begin
      step(1, x, 5);
      if (x == 16)  chk16("grid (16,5)", pixel_data, 16'hFFFF);
      if (x == 17)  chk16("grid (17,5)", pixel_data, 16'h0000);
      if (x == 799) chk16("grid (799,5)", pixel_data, 16'hFFFF);
    end
    for (int x = 0; x <= 10; x++) begin
      step(1, x, 479);
      if (x == 5) chk16("grid (5,479)", pixel_data, 16'hFFFF);
    end

    // Reserved mode
    mode = 3'd6;
    for (int x = 0; x < 64; x++) step(1, x, 0);
    for (int x = 0; x < 64; x++) step(1, x, 7);

    // Asynchronous reset in the middle of a bar line
    mode = 3'd0;
    for (int x = 0; x < 50; x++) step(1, x, 0);
    #2 rst_n = 1'b0;
    #1;
    chk16("async reset pixel_data", pixel_data, 16'h0000);
    chk1("async reset pixel_valid", pixel_valid, 1'b0);
    chk16("async reset pixel_data3", pixel_data3, 16'h0000);
    data_req = 1'b0;
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
    repeat (2) @(posedge lcd_pclk);
    @(negedge lcd_pclk) rst_n = 1'b1;

    // Bouncing box: one frame-start request per frame
    mode = 3'd5;
    step(1, 0, 0);
    chk16("box at reset origin", pixel_data, 16'hF800);
    for (int f = 2; f <= 768; f++) step(1, 0, 0);
    step(1, 768, m_by);
    chk16("box x=768 left edge", pixel_data, 16'hF800);
    step(1, 767, m_by);
    chk16("box x=768 outside left", pixel_data, 16'h001F);
    step(1, 0, 0);
    step(1, 767, m_by);
    chk16("box x=767 after bounce", pixel_data, 16'hF800);
    step(1, 799, m_by);
    chk16("box x+32 outside", pixel_data, 16'h001F);
    step(1, 766, m_by);
    chk16("box x-1 outside", pixel_data, 16'h001F);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
